// File: rtl/id_branch_btb_pkg.sv
// branch_pkg: shared definitions for the ID-stage branch unit and its BTB.
//   - opcode constants for the four control-transfer instructions
//   - condition codes carried in imm[2:0] of BR/BRL
//   - BTB entry layout and the counter value used on allocation
//   - ctr_step(): 2-bit saturating counter update
// No ports; imported by every other file of the block.
package branch_pkg;

  // Width of the tag/target fields stored in an entry. Tags are stored
  // zero-extended to this width, so the unit's XLEN must not exceed it.
  localparam int BTB_XLEN = 32;

  localparam logic [4:0] OP_BR  = 5'd15;
  localparam logic [4:0] OP_BRL = 5'd16;
  localparam logic [4:0] OP_J   = 5'd17;
  localparam logic [4:0] OP_JL  = 5'd18;

  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_ALWAYS = 3'd1;
  localparam logic [2:0] COND_EQZ    = 3'd2;
  localparam logic [2:0] COND_NEZ    = 3'd3;
  localparam logic [2:0] COND_GEZ    = 3'd4;
  localparam logic [2:0] COND_LTZ    = 3'd5;

  // Newly allocated entries start weakly taken.
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  typedef struct packed {
    logic                valid;
    logic [1:0]          ctr;
    logic [BTB_XLEN-1:0] tag;
    logic [BTB_XLEN-1:0] target;
  } btb_entry_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/id_branch_btb_if.sv
// id_branch_btb_if: all non-clock signals of the branch unit.
//   Fetch side : if_pc -> if_pred_taken / if_pred_target (combinational)
//   ID side    : id_valid, id_stall, id_pc, id_opcode, id_imm, id_data1,
//                id_data2, id_branch, id_pred_taken, id_pred_target
//   Redirect   : redirect_valid / redirect_pc (registered, one-cycle pulse)
// Modports: master = pipeline driving the unit, slave = the unit itself.
//
// Handshake: there is no ready. An ID instruction is consumed in any cycle
// where id_valid & id_branch & !id_stall holds and no redirect is being
// presented; id_stall holds the instruction without consuming it.
interface id_branch_btb_if #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 22
);
  logic             if_pc_dummy_unused;
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic [XLEN-1:0]  if_pred_target;
  logic             id_valid;
  logic             id_stall;
  logic [XLEN-1:0]  id_pc;
  logic [4:0]       id_opcode;
  logic [IMM_W-1:0] id_imm;
  logic [XLEN-1:0]  id_data1;
  logic [XLEN-1:0]  id_data2;
  logic             id_branch;
  logic             id_pred_taken;
  logic [XLEN-1:0]  id_pred_target;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;

  assign if_pc_dummy_unused = 1'b0;

  modport master (
    output if_pc, id_valid, id_stall, id_pc, id_opcode, id_imm, id_data1,
           id_data2, id_branch, id_pred_taken, id_pred_target,
    input  if_pred_taken, if_pred_target, redirect_valid, redirect_pc
  );

  modport slave (
    input  if_pc, id_valid, id_stall, id_pc, id_opcode, id_imm, id_data1,
           id_data2, id_branch, id_pred_taken, id_pred_target,
    output if_pred_taken, if_pred_target, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/id_branch_btb_cond_eval.sv
// branch_cond_eval: combinational taken decision for one ID instruction.
//   opcode in 5     : instruction opcode
//   cond   in 3     : imm[2:0], condition code for BR/BRL
//   data2  in XLEN  : signed condition operand
//   taken  out 1    : J/JL always taken; BR/BRL per cond; others never
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      opcode,
  input  logic [2:0]      cond,
  input  logic [XLEN-1:0] data2,
  output logic            taken
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (data2 == '0);
  assign is_neg  = data2[XLEN-1];

  always_comb begin
    taken = 1'b0;
    if (opcode == OP_J || opcode == OP_JL) begin
      taken = 1'b1;
    end else if (opcode == OP_BR || opcode == OP_BRL) begin
      case (cond)
        COND_ALWAYS: taken = 1'b1;
        COND_EQZ:    taken = is_zero;
        COND_NEZ:    taken = !is_zero;
        COND_GEZ:    taken = !is_neg;
        COND_LTZ:    taken = is_neg;
        default:     taken = 1'b0; // COND_NEVER and the unused codes 6, 7
      endcase
    end
  end

endmodule

// File: rtl/id_branch_btb.sv
// id_branch_btb: ID-stage branch resolution with a direct-mapped BTB.
//   CLK   in : rising-edge clock
//   RSTN  in : asynchronous active-low reset
//   bus      : id_branch_btb_if.slave (fetch lookup, ID resolution, redirect)
// Fetch lookup is combinational from bus.if_pc. A resolved mispredict raises
// bus.redirect_valid for exactly one cycle with the correct next PC.
//
// Build option: define ID_BRANCH_BTB_EN to include the prediction table.
// Without it there is no storage, predictions are tied to 0, and every taken
// branch (relative to its carried prediction) redirects.
module id_branch_btb
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IMM_W     = 22,
  parameter int BTB_DEPTH = 64,
  parameter int IDX_W     = $clog2(BTB_DEPTH)
) (
  input logic            CLK,
  input logic            RSTN,
  id_branch_btb_if.slave bus
);

  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            is_j_op;
  logic            res;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] correct_pc;

  assign is_j_op = (bus.id_opcode == OP_J) || (bus.id_opcode == OP_JL);

  // The cycle right after a redirect holds a wrong-path instruction.
  assign res = bus.id_valid & bus.id_branch & ~bus.id_stall & ~redirect_valid_q;

  branch_cond_eval #(
    .XLEN (XLEN)
  ) u_cond (
    .opcode (bus.id_opcode),
    .cond   (bus.id_imm[2:0]),
    .data2  (bus.id_data2),
    .taken  (taken)
  );

  assign imm_sext   = {{(XLEN-IMM_W){bus.id_imm[IMM_W-1]}}, bus.id_imm};
  assign res_target = is_j_op ? (bus.id_pc + imm_sext) : bus.id_data1;

  // Target only matters when both sides agree the branch is taken.
  assign mispredict = res & ((taken != bus.id_pred_taken) |
                             (taken & (res_target != bus.id_pred_target)));
  assign correct_pc = taken ? res_target : (bus.id_pc + XLEN'(4));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= mispredict;
      if (mispredict) redirect_pc_q <= correct_pc;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

`ifdef ID_BRANCH_BTB_EN

  btb_entry_t btb_q [BTB_DEPTH];

  logic                is_branch_op;
  logic [IDX_W-1:0]    idx_f;
  logic [BTB_XLEN-1:0] tag_f;
  btb_entry_t          ent_f;
  logic                pred_f;
  logic [IDX_W-1:0]    idx_d;
  logic [BTB_XLEN-1:0] tag_d;
  btb_entry_t          ent_d;
  logic                hit_d;
  logic                upd_en;
  btb_entry_t          upd_entry;
  logic                unused_pc_bits;

  assign is_branch_op = (bus.id_opcode == OP_BR) || (bus.id_opcode == OP_BRL) || is_j_op;

  // Fetch lookup: reads the array as it stands, so a same-cycle update to
  // the same index is seen only from the next cycle on.
  assign idx_f  = bus.if_pc[IDX_W+1:2];
  assign tag_f  = BTB_XLEN'(bus.if_pc >> (IDX_W + 2));
  assign ent_f  = btb_q[idx_f];
  assign pred_f = ent_f.valid && (ent_f.tag == tag_f) && ent_f.ctr[1];

  assign bus.if_pred_taken  = pred_f;
  assign bus.if_pred_target = pred_f ? XLEN'(ent_f.target) : '0;

  assign idx_d = bus.id_pc[IDX_W+1:2];
  assign tag_d = BTB_XLEN'(bus.id_pc >> (IDX_W + 2));
  assign ent_d = btb_q[idx_d];
  assign hit_d = ent_d.valid && (ent_d.tag == tag_d);

  // A not-taken miss leaves the table alone; everything else resolved writes.
  assign upd_en = res & is_branch_op & (hit_d | taken);

  always_comb begin
    upd_entry = ent_d;
    if (hit_d) begin
      upd_entry.ctr = ctr_step(ent_d.ctr, taken);
      if (taken) upd_entry.target = BTB_XLEN'(res_target);
    end else begin
      upd_entry.valid  = 1'b1;
      upd_entry.ctr    = CTR_ALLOC;
      upd_entry.tag    = tag_d;
      upd_entry.target = BTB_XLEN'(res_target);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < BTB_DEPTH; i++) btb_q[i] <= '0;
    end else if (upd_en) begin
      btb_q[idx_d] <= upd_entry;
    end
  end

  assign unused_pc_bits = ^bus.if_pc[1:0];

`else

  logic unused_cfg_bits;

  assign bus.if_pred_taken  = 1'b0;
  assign bus.if_pred_target = '0;

  assign unused_cfg_bits = ^{bus.if_pc, IDX_W[0]};

`endif

endmodule

// File: tb/tb_id_branch_btb.sv
// Testbench for id_branch_btb with a 4-entry table (small enough that
// aliasing addresses are easy to construct). A behavioural model of the
// branch rules and the table drives a per-cycle comparison; directed
// sequences add hand-computed literal expectations.
module tb_id_branch_btb;

  localparam int DEPTH = 4;
  localparam int IW    = $clog2(DEPTH);
`ifdef ID_BRANCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  id_branch_btb_if #(.XLEN(32), .IMM_W(22)) bus ();

  id_branch_btb #(
    .XLEN      (32),
    .IMM_W     (22),
    .BTB_DEPTH (DEPTH)
  ) dut (
    .CLK  (clk),
    .RSTN (rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  bit          m_rv;
  logic [32:0] exp_q[$];  // {redirect_valid, redirect_pc} per resolved cycle

  function automatic logic [32:0] model_lookup(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % DEPTH);
    if (BTB_ON && m_valid[i] && m_tag[i] == (pc >> (2 + IW)) && m_ctr[i] >= 2)
      return {1'b1, m_tgt[i]};
    return 33'd0;
  endfunction

  task automatic model_step();
    logic [31:0] pc, tgt, cpc, tag;
    logic [4:0]  op;
    logic [21:0] imm;
    logic        taken, res, is_br, is_j, mis;
    int          i;
    pc    = bus.id_pc;
    op    = bus.id_opcode;
    imm   = bus.id_imm;
    is_br = (op == 5'd15) || (op == 5'd16);
    is_j  = (op == 5'd17) || (op == 5'd18);
    res   = bus.id_valid && bus.id_branch && !bus.id_stall && !m_rv;
    taken = 1'b0;
    tgt   = 32'd0;
    if (is_j) begin
      taken = 1'b1;
      tgt   = pc + {{10{imm[21]}}, imm};
    end else if (is_br) begin
      tgt = bus.id_data1;
      case (imm[2:0])
        3'd1: taken = 1'b1;
        3'd2: taken = (bus.id_data2 == 32'd0);
        3'd3: taken = (bus.id_data2 != 32'd0);
        3'd4: taken = ($signed(bus.id_data2) >= 0);
        3'd5: taken = ($signed(bus.id_data2) < 0);
        default: taken = 1'b0;
      endcase
    end
    mis = res && ((taken != bus.id_pred_taken) || (taken && tgt != bus.id_pred_target));
    cpc = taken ? tgt : pc + 32'd4;
    if (BTB_ON && res && (is_br || is_j)) begin
      i   = int'((pc >> 2) % DEPTH);
      tag = pc >> (2 + IW);
      if (m_valid[i] && m_tag[i] == tag) begin
        if (taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag;
        m_tgt[i]   = tgt;
        m_ctr[i]   = 2;
      end
    end
    m_rv = mis;
    exp_q.push_back({mis, cpc});
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step();
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    m_rv = 1'b0;
    exp_q.delete();
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] p;
    logic [32:0] e;
    if (rst_n) begin
      p = model_lookup(bus.if_pc);
      check("model_if_pred_taken", 32'(bus.if_pred_taken), 32'(p[32]));
      check("model_if_pred_target", bus.if_pred_target, p[31:0]);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("model_redirect_valid", 32'(bus.redirect_valid), 32'(e[32]));
        if (e[32]) check("model_redirect_pc", bus.redirect_pc, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] op, input logic [31:0] pc, input logic [21:0] imm,
                       input logic [31:0] d1, input logic [31:0] d2, input logic pt,
                       input logic [31:0] ptgt, input logic stall, input logic br_en);
    @(posedge clk);
    #1;
    bus.id_valid       = 1'b1;
    bus.id_branch      = br_en;
    bus.id_stall       = stall;
    bus.id_opcode      = op;
    bus.id_pc          = pc;
    bus.id_imm         = imm;
    bus.id_data1       = d1;
    bus.id_data2       = d2;
    bus.id_pred_taken  = pt;
    bus.id_pred_target = ptgt;
    bus.if_pc          = pc;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.id_valid      = 1'b0;
    bus.id_branch     = 1'b0;
    bus.id_stall      = 1'b0;
    bus.id_pred_taken = 1'b0;
  endtask

  task automatic expect_redirect(input string name, input logic v, input logic [31:0] pc);
    @(negedge clk);
    check({name, "_valid"}, 32'(bus.redirect_valid), 32'(v));
    if (v) check({name, "_pc"}, bus.redirect_pc, pc);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    bus.if_pc = pc;
    #1;
    check({name, "_taken"}, 32'(bus.if_pred_taken), BTB_ON ? 32'(t) : 32'd0);
    check({name, "_target"}, bus.if_pred_target, BTB_ON ? tgt : 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]  v_cond  [10] = '{3'd0, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd2};
  logic [31:0] v_d2    [10] = '{32'd0, 32'd7, 32'd0, 32'h8000_0000, 32'd0,
                                32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1};
  logic        v_taken [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    rst_n              = 1'b0;
    bus.if_pc          = 32'h100;
    bus.id_valid       = 1'b0;
    bus.id_stall       = 1'b0;
    bus.id_pc          = '0;
    bus.id_opcode      = '0;
    bus.id_imm         = '0;
    bus.id_data1       = '0;
    bus.id_data2       = '0;
    bus.id_branch      = 1'b0;
    bus.id_pred_taken  = 1'b0;
    bus.id_pred_target = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("reset_redirect_pc", bus.redirect_pc, 32'd0);
    check("reset_pred_taken", 32'(bus.if_pred_taken), 32'd0);
    check("reset_pred_target", bus.if_pred_target, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // J at 0x100, imm -8, predicted not taken
    drive(5'd17, 32'h100, 22'h3FFFF8, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    idle();
    expect_redirect("j_back", 1'b1, 32'hF8);
    look("j_back_lookup", 32'h100, 1'b1, 32'hF8);
    idle();
    expect_redirect("j_back_clear", 1'b0, 0);

    // BR eqz taken, predicted correctly: allocate, then strengthen
    drive(5'd15, 32'h200, 22'd2, 32'h400, 32'd0, 1'b1, 32'h400, 1'b0, 1'b1);
    idle();
    expect_redirect("br_eqz_1", 1'b0, 0);
    look("br_evicts_j", 32'h100, 1'b0, 0);
    drive(5'd15, 32'h200, 22'd2, 32'h400, 32'd0, 1'b1, 32'h400, 1'b0, 1'b1);
    idle();
    expect_redirect("br_eqz_2", 1'b0, 0);

    // Same branch now not taken: 11 -> 10 still predicts taken, 01 does not
    drive(5'd15, 32'h200, 22'd2, 32'h400, 32'd5, 1'b1, 32'h400, 1'b0, 1'b1);
    idle();
    expect_redirect("br_nt_1", 1'b1, 32'h204);
    look("br_ctr10", 32'h200, 1'b1, 32'h400);
    drive(5'd15, 32'h200, 22'd2, 32'h400, 32'd5, 1'b0, 32'h0, 1'b0, 1'b1);
    idle();
    expect_redirect("br_nt_2", 1'b0, 0);
    look("br_ctr01", 32'h200, 1'b0, 0);

    // Stall holds a mispredicting J; release resolves it
    drive(5'd17, 32'h108, 22'h20, 0, 0, 1'b0, 0, 1'b1, 1'b1);
    drive(5'd17, 32'h108, 22'h20, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("stall_no_redirect", 32'(bus.redirect_valid), 32'd0);
    look("stall_no_update", 32'h108, 1'b0, 0);
    idle();
    expect_redirect("stall_release", 1'b1, 32'h128);
    idle();

    // Shadow: the instruction right after a mispredict is ignored
    drive(5'd17, 32'h10C, 22'h40, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    drive(5'd17, 32'h104, 22'h40, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    expect_redirect("shadow_first", 1'b1, 32'h14C);
    idle();
    expect_redirect("shadow_second", 1'b0, 0);
    look("shadow_no_alloc", 32'h104, 1'b0, 0);
    look("shadow_first_alloc", 32'h10C, 1'b1, 32'h14C);

    // Alias: 0x10 and 0x20 share index 0 in a 4-entry table
    drive(5'd15, 32'h10, 22'd1, 32'h80, 0, 1'b1, 32'h80, 1'b0, 1'b1);
    idle();
    expect_redirect("alias_a", 1'b0, 0);
    look("alias_a_lookup", 32'h10, 1'b1, 32'h80);
    drive(5'd15, 32'h20, 22'd1, 32'h90, 0, 1'b1, 32'h90, 1'b0, 1'b1);
    idle();
    expect_redirect("alias_b", 1'b0, 0);
    look("alias_a_evicted", 32'h10, 1'b0, 0);
    look("alias_b_lookup", 32'h20, 1'b1, 32'h90);

    // Condition codes, all predicted not taken
    for (int k = 0; k < 10; k++) begin
      drive(5'd15, 32'h304, {19'd0, v_cond[k]}, 32'h500, v_d2[k], 1'b0, 0, 1'b0, 1'b1);
      idle();
      expect_redirect("cond_vec", v_taken[k], 32'h500);
    end

    // JL taken with wrong predicted target
    drive(5'd18, 32'h300, 22'h10, 0, 0, 1'b1, 32'h314, 1'b0, 1'b1);
    idle();
    expect_redirect("jl_target", 1'b1, 32'h310);

    // Non-branch opcode predicted taken: redirect to pc+4, no allocation
    drive(5'd3, 32'h308, 22'd1, 32'h600, 0, 1'b1, 32'h600, 1'b0, 1'b1);
    idle();
    expect_redirect("nonbranch", 1'b1, 32'h30C);
    look("nonbranch_no_alloc", 32'h308, 1'b0, 0);
    idle();

    // Decoder branch enable low: ignored
    drive(5'd17, 32'h400, 22'h8, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    idle();
    expect_redirect("branch_en_low", 1'b0, 0);

    // J target wraps modulo 2^32
    drive(5'd17, 32'h4, 22'h3FFFF8, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    idle();
    expect_redirect("j_wrap", 1'b1, 32'hFFFF_FFFC);
    idle();

    // BRL always, predicted correctly
    drive(5'd16, 32'h30, 22'd1, 32'h700, 0, 1'b1, 32'h700, 1'b0, 1'b1);
    idle();
    expect_redirect("brl_ok", 1'b0, 0);

    // Reset while a redirect is being presented
    drive(5'd17, 32'h500, 22'h8, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus.id_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("rst_drop_valid", 32'(bus.redirect_valid), 32'd0);
    check("rst_drop_pc", bus.redirect_pc, 32'd0);
    look("rst_table_clear", 32'h20, 1'b0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    expect_redirect("after_reset", 1'b0, 0);
    idle();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
